mem_arb: RTL and testbench



---
 rtl/mem_arb_if.sv | 42 ++++
 rtl/mem_arb.sv | 113 +++++++++++
 tb/tb_mem_arb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Bus bundle between the core requesters, the memory controller and mem_arb.
// master = environment side (requesters + memory), slave = the arbiter.
interface mem_arb_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          req0_i_w;
  logic          wr0_i_w;
  logic [AW-1:0] addr0_i_w;
  logic [DW-1:0] wdat0_i_w;
  logic          ack0_o_r;
  logic [DW-1:0] rdat0_o_r;

  logic          req1_i_w;
  logic          wr1_i_w;
  logic [AW-1:0] addr1_i_w;
  logic [DW-1:0] wdat1_i_w;
  logic          ack1_o_r;
  logic [DW-1:0] rdat1_o_r;

  logic          men_o_r;
  logic [AW-1:0] maddr_o_r;
  logic          mwr_o_r;
  logic [DW-1:0] mwdat_o_r;
  logic [DW-1:0] mrdat_i_w;

  modport master (
    output req0_i_w, wr0_i_w, addr0_i_w, wdat0_i_w,
    output req1_i_w, wr1_i_w, addr1_i_w, wdat1_i_w,
    output mrdat_i_w,
    input  ack0_o_r, rdat0_o_r, ack1_o_r, rdat1_o_r,
    input  men_o_r, maddr_o_r, mwr_o_r, mwdat_o_r
  );

  modport slave (
    input  req0_i_w, wr0_i_w, addr0_i_w, wdat0_i_w,
    input  req1_i_w, wr1_i_w, addr1_i_w, wdat1_i_w,
    input  mrdat_i_w,
    output ack0_o_r, rdat0_o_r, ack1_o_r, rdat1_o_r,
    output men_o_r, maddr_o_r, mwr_o_r, mwdat_o_r
  );
endinterface

// File: rtl/mem_arb.sv
// Two-port arbiter sharing one single-ported memory between fetch (port 0)
// and load/store (port 1); one enabled memory cycle per grant, then a 1-cycle ack.
module mem_arb #(
  parameter bit RR_EN = 1'b1
) (
  input logic      clk_i_w,
  input logic      rst_i_w,
  mem_arb_if.slave bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t        state_r, state_nxt;
  logic          gnt_r, gnt_nxt;
  logic          last_r, last_nxt;
  logic          win_c;
  logic          men_nxt, mwr_nxt, ack0_nxt, ack1_nxt;
  logic [AW-1:0] maddr_nxt;
  logic [DW-1:0] mwdat_nxt, rdat0_nxt, rdat1_nxt;

  // Winner: a lone requester wins; on a tie round-robin or port 0.
  always_comb begin
    if (bus.req0_i_w && bus.req1_i_w) win_c = RR_EN ? ~last_r : 1'b0;
    else                              win_c = bus.req1_i_w;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      state_r       <= IDLE;
      gnt_r         <= 1'b0;
      last_r        <= 1'b1;
      bus.men_o_r   <= 1'b0;
      bus.maddr_o_r <= '0;
      bus.mwr_o_r   <= 1'b0;
      bus.mwdat_o_r <= '0;
      bus.ack0_o_r  <= 1'b0;
      bus.ack1_o_r  <= 1'b0;
      bus.rdat0_o_r <= '0;
      bus.rdat1_o_r <= '0;
    end else begin
      state_r       <= state_nxt;
      gnt_r         <= gnt_nxt;
      last_r        <= last_nxt;
      bus.men_o_r   <= men_nxt;
      bus.maddr_o_r <= maddr_nxt;
      bus.mwr_o_r   <= mwr_nxt;
      bus.mwdat_o_r <= mwdat_nxt;
      bus.ack0_o_r  <= ack0_nxt;
      bus.ack1_o_r  <= ack1_nxt;
      bus.rdat0_o_r <= rdat0_nxt;
      bus.rdat1_o_r <= rdat1_nxt;
    end
  end

  // Next state.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (bus.req0_i_w || bus.req1_i_w) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of grant bookkeeping and registered outputs.
  always_comb begin
    gnt_nxt   = gnt_r;
    last_nxt  = last_r;
    men_nxt   = bus.men_o_r;
    maddr_nxt = bus.maddr_o_r;
    mwr_nxt   = bus.mwr_o_r;
    mwdat_nxt = bus.mwdat_o_r;
    ack0_nxt  = bus.ack0_o_r;
    ack1_nxt  = bus.ack1_o_r;
    rdat0_nxt = bus.rdat0_o_r;
    rdat1_nxt = bus.rdat1_o_r;
    case (state_r)
      IDLE: begin
        if (bus.req0_i_w || bus.req1_i_w) begin
          gnt_nxt   = win_c;
          last_nxt  = win_c;
          men_nxt   = 1'b1;
          maddr_nxt = win_c ? bus.addr1_i_w : bus.addr0_i_w;
          mwr_nxt   = win_c ? bus.wr1_i_w   : bus.wr0_i_w;
          mwdat_nxt = win_c ? bus.wdat1_i_w : bus.wdat0_i_w;
        end
      end
      ACCESS: begin
        // Read data is only valid while men is high, so capture it here.
        men_nxt  = 1'b0;
        ack0_nxt = ~gnt_r;
        ack1_nxt = gnt_r;
        if (!bus.mwr_o_r) begin
          if (gnt_r) rdat1_nxt = bus.mrdat_i_w;
          else       rdat0_nxt = bus.mrdat_i_w;
        end
      end
      ACK: begin
        ack0_nxt = 1'b0;
        ack1_nxt = 1'b0;
      end
      default: begin
        men_nxt  = 1'b0;
        ack0_nxt = 1'b0;
        ack1_nxt = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: one round-robin and one fixed-priority instance,
// each with a small behavioural memory.
module tb_mem_arb;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad   = 0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_a  = '0;
  logic [15:0] pl_d  = '0;
  logic        exp_p, exp_n, both;

  logic [15:0] mem_rr [65536];
  logic [15:0] mem_fp [65536];

  mem_arb_if rr ();
  mem_arb_if fp ();

  mem_arb #(.RR_EN(1'b1)) dut_rr (.clk_i_w(clk), .rst_i_w(rst_n), .bus(rr));
  mem_arb #(.RR_EN(1'b0)) dut_fp (.clk_i_w(clk), .rst_i_w(rst_n), .bus(fp));

  always #5 clk = ~clk;

  // Memory model: writes on the edge while enabled, reads combinationally.
  always_ff @(posedge clk) begin
    if (pl_en) begin
      mem_rr[pl_a] <= pl_d;
      mem_fp[pl_a] <= pl_d;
    end else begin
      if (rr.men_o_r && rr.mwr_o_r) mem_rr[rr.maddr_o_r] <= rr.mwdat_o_r;
      if (fp.men_o_r && fp.mwr_o_r) mem_fp[fp.maddr_o_r] <= fp.mwdat_o_r;
    end
  end
  assign rr.mrdat_i_w = mem_rr[rr.maddr_o_r];
  assign fp.mrdat_i_w = mem_fp[fp.maddr_o_r];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    tick();
    pl_en = 1'b0;
  endtask

  initial begin
    rr.req0_i_w = 1'b0; rr.wr0_i_w = 1'b0; rr.addr0_i_w = '0; rr.wdat0_i_w = '0;
    rr.req1_i_w = 1'b0; rr.wr1_i_w = 1'b0; rr.addr1_i_w = '0; rr.wdat1_i_w = '0;
    fp.req0_i_w = 1'b0; fp.wr0_i_w = 1'b0; fp.addr0_i_w = '0; fp.wdat0_i_w = '0;
    fp.req1_i_w = 1'b0; fp.wr1_i_w = 1'b0; fp.addr1_i_w = '0; fp.wdat1_i_w = '0;

    preload(16'd5, 16'h1234);
    preload(16'd6, 16'h0606);
    preload(16'd3, 16'h0303);
    preload(16'd4, 16'h0404);

    check("rst_men",   16'(rr.men_o_r),  16'd0);
    check("rst_maddr", rr.maddr_o_r,     16'd0);
    check("rst_mwr",   16'(rr.mwr_o_r),  16'd0);
    check("rst_mwdat", rr.mwdat_o_r,     16'd0);
    check("rst_ack0",  16'(rr.ack0_o_r), 16'd0);
    check("rst_ack1",  16'(rr.ack1_o_r), 16'd0);
    check("rst_rdat0", rr.rdat0_o_r,     16'd0);
    check("rst_rdat1", rr.rdat1_o_r,     16'd0);
    check("rst_fp_men", 16'(fp.men_o_r), 16'd0);
    rst_n = 1'b1;
    tick();

    // Single read on port 0.
    rr.req0_i_w = 1'b1; rr.addr0_i_w = 16'd5; rr.wr0_i_w = 1'b0;
    tick();
    check("rd0_men",   16'(rr.men_o_r),  16'd1);
    check("rd0_maddr", rr.maddr_o_r,     16'd5);
    check("rd0_mwr",   16'(rr.mwr_o_r),  16'd0);
    check("rd0_early_ack", 16'(rr.ack0_o_r), 16'd0);
    tick();
    check("rd0_ack0",  16'(rr.ack0_o_r), 16'd1);
    check("rd0_ack1",  16'(rr.ack1_o_r), 16'd0);
    check("rd0_men_off", 16'(rr.men_o_r), 16'd0);
    check("rd0_rdat0", rr.rdat0_o_r,     16'h1234);
    check("rd0_rdat1", rr.rdat1_o_r,     16'd0);
    rr.req0_i_w = 1'b0;
    tick();
    check("rd0_ack_clr", 16'(rr.ack0_o_r), 16'd0);
    tick();
    check("rd0_no_rerun", 16'(rr.men_o_r), 16'd0);

    // Single write on port 1, read back through port 0.
    rr.req1_i_w = 1'b1; rr.addr1_i_w = 16'd10; rr.wr1_i_w = 1'b1; rr.wdat1_i_w = 16'hBEEF;
    tick();
    check("wr1_men",   16'(rr.men_o_r), 16'd1);
    check("wr1_mwr",   16'(rr.mwr_o_r), 16'd1);
    check("wr1_maddr", rr.maddr_o_r,    16'd10);
    check("wr1_mwdat", rr.mwdat_o_r,    16'hBEEF);
    tick();
    check("wr1_ack1",  16'(rr.ack1_o_r), 16'd1);
    check("wr1_ack0",  16'(rr.ack0_o_r), 16'd0);
    check("wr1_rdat1", rr.rdat1_o_r,     16'd0);
    rr.req1_i_w = 1'b0; rr.wr1_i_w = 1'b0;
    tick();
    rr.req0_i_w = 1'b1; rr.addr0_i_w = 16'd10;
    tick();
    tick();
    check("rb0_ack0",  16'(rr.ack0_o_r), 16'd1);
    check("rb0_rdat0", rr.rdat0_o_r,     16'hBEEF);
    rr.req0_i_w = 1'b0;
    tick();

    // Both held, round robin: last grant was port 0, so port 1 goes first.
    rr.req0_i_w = 1'b1; rr.addr0_i_w = 16'd5;
    rr.req1_i_w = 1'b1; rr.addr1_i_w = 16'd10;
    for (int i = 0; i < 4; i++) begin
      exp_p = (i % 2 == 0) ? 1'b1 : 1'b0;
      exp_n = ~exp_p;
      tick();
      check("rr_men",   16'(rr.men_o_r), 16'd1);
      check("rr_maddr", rr.maddr_o_r, exp_p ? 16'd10 : 16'd5);
      tick();
      both = rr.ack0_o_r & rr.ack1_o_r;
      check("rr_ack0", 16'(rr.ack0_o_r), 16'(exp_n));
      check("rr_ack1", 16'(rr.ack1_o_r), 16'(exp_p));
      check("rr_both", 16'(both), 16'd0);
      check("rr_rdat", exp_p ? rr.rdat1_o_r : rr.rdat0_o_r, exp_p ? 16'hBEEF : 16'h1234);
      tick();
      both = rr.ack0_o_r | rr.ack1_o_r;
      check("rr_ack_gap", 16'(both), 16'd0);
    end
    rr.req0_i_w = 1'b0; rr.req1_i_w = 1'b0;
    tick();
    check("rr_idle", 16'(rr.men_o_r), 16'd0);

    // Fixed priority: port 0 keeps requesting and wins every arbitration.
    fp.req0_i_w = 1'b1; fp.addr0_i_w = 16'd3;
    fp.req1_i_w = 1'b1; fp.addr1_i_w = 16'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fp_maddr", fp.maddr_o_r, 16'd3);
      tick();
      check("fp_ack0", 16'(fp.ack0_o_r), 16'd1);
      check("fp_ack1", 16'(fp.ack1_o_r), 16'd0);
      tick();
    end
    check("fp_rdat0", fp.rdat0_o_r, 16'h0303);
    fp.req0_i_w = 1'b0;
    tick();
    check("fp_p1_maddr", fp.maddr_o_r, 16'd4);
    tick();
    check("fp_p1_ack1",  16'(fp.ack1_o_r), 16'd1);
    check("fp_p1_rdat1", fp.rdat1_o_r,     16'h0404);
    fp.req1_i_w = 1'b0;
    tick();
    tick();
    check("fp_idle", 16'(fp.men_o_r), 16'd0);

    // Back-to-back on port 0 with a one-cycle gap and a new address.
    rr.req0_i_w = 1'b1; rr.addr0_i_w = 16'd5;
    tick();
    tick();
    check("b2b_ack_a", 16'(rr.ack0_o_r), 16'd1);
    tick();
    rr.req0_i_w = 1'b0;
    check("b2b_ack_clr", 16'(rr.ack0_o_r), 16'd0);
    tick();
    check("b2b_no_dup_men", 16'(rr.men_o_r),  16'd0);
    check("b2b_no_dup_ack", 16'(rr.ack0_o_r), 16'd0);
    rr.req0_i_w = 1'b1; rr.addr0_i_w = 16'd6;
    tick();
    check("b2b_men",   16'(rr.men_o_r), 16'd1);
    check("b2b_maddr", rr.maddr_o_r,    16'd6);
    tick();
    check("b2b_ack_b", 16'(rr.ack0_o_r), 16'd1);
    check("b2b_rdat0", rr.rdat0_o_r,     16'h0606);
    rr.req0_i_w = 1'b0;
    tick();
    tick();

    // Reset in the middle of ACCESS, request still held.
    rr.req0_i_w = 1'b1; rr.addr0_i_w = 16'd5;
    tick();
    check("rst_mid_men_pre", 16'(rr.men_o_r), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_men",   16'(rr.men_o_r),  16'd0);
    check("rst_mid_maddr", rr.maddr_o_r,     16'd0);
    check("rst_mid_ack0",  16'(rr.ack0_o_r), 16'd0);
    check("rst_mid_rdat0", rr.rdat0_o_r,     16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_rerun_men",   16'(rr.men_o_r), 16'd1);
    check("rst_rerun_maddr", rr.maddr_o_r,    16'd5);
    tick();
    check("rst_rerun_ack0",  16'(rr.ack0_o_r), 16'd1);
    check("rst_rerun_rdat0", rr.rdat0_o_r,     16'h1234);
    rr.req0_i_w = 1'b0;
    tick();
    check("rst_rerun_clr", 16'(rr.ack0_o_r), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
